call_scheduler: RTL and testbench

//  Latches car (btn_in) and hall (btn_up_out/btn_down_out) calls and keeps them pending until served.

---
 rtl/call_scheduler_pkg.sv | 12 +
 rtl/call_scheduler_finder.sv | 80 ++++++++
 rtl/call_scheduler.sv | 152 +++++++++++++++
 tb/tb_call_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/call_scheduler_pkg.sv
// Shared elevator definitions: default floor count, floor index width and scheduler state encoding.
// Pure declarations; no logic, no latency, no flow control.
package call_scheduler_pkg;
    localparam int DEF_FLOORS  = 8;
    localparam int DEF_FLOOR_W = $clog2(DEF_FLOORS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;
endpackage

// File: rtl/call_scheduler_finder.sv
// Combinational search over pending calls relative to the car: calls above/below, nearest call, next up/down stops.
// Zero latency; no flow control.
module call_finder #(
    parameter int N  = 8,
    parameter int FW = 3
) (
    input  logic [N-1:0]  i_car,
    input  logic [N-1:0]  i_up,
    input  logic [N-1:0]  i_dn,
    input  logic [FW-1:0] i_cur,
    input  logic          i_at,
    output logic          o_any_above,
    output logic          o_any_below,
    output logic          o_call_here,
    output logic          o_near_up,
    output logic [FW-1:0] o_near_floor,
    output logic          o_up_vld,
    output logic [FW-1:0] o_up_floor,
    output logic          o_dn_vld,
    output logic [FW-1:0] o_dn_floor
);
    logic [N-1:0]  w_any;
    logic [FW-1:0] w_above_f, w_below_f, w_ahu_f, w_rvu_f, w_ahd_f, w_rvd_f;
    logic          w_ahu_vld, w_rvu_vld, w_ahd_vld, w_rvd_vld;

    assign w_any       = i_car | i_up | i_dn;
    assign o_call_here = w_any[i_cur];

    // Descending scan keeps the lowest hit, ascending scan keeps the highest hit.
    always_comb begin
        o_any_above = 1'b0;
        o_any_below = 1'b0;
        w_above_f   = '0;
        w_below_f   = '0;
        w_ahu_vld   = 1'b0;
        w_ahu_f     = '0;
        w_rvu_vld   = 1'b0;
        w_rvu_f     = '0;
        w_ahd_vld   = 1'b0;
        w_ahd_f     = '0;
        w_rvd_vld   = 1'b0;
        w_rvd_f     = '0;
        for (int f = N - 1; f >= 0; f--) begin
            if (f > int'(i_cur) && w_any[f]) begin
                o_any_above = 1'b1;
                w_above_f   = FW'(f);
            end
            if ((f > int'(i_cur) || (f == int'(i_cur) && i_at)) && (i_car[f] || i_up[f])) begin
                w_ahu_vld = 1'b1;
                w_ahu_f   = FW'(f);
            end
            if (f < int'(i_cur) && i_up[f]) begin
                w_rvd_vld = 1'b1;
                w_rvd_f   = FW'(f);
            end
        end
        for (int f = 0; f < N; f++) begin
            if (f < int'(i_cur) && w_any[f]) begin
                o_any_below = 1'b1;
                w_below_f   = FW'(f);
            end
            if ((f < int'(i_cur) || (f == int'(i_cur) && i_at)) && (i_car[f] || i_dn[f])) begin
                w_ahd_vld = 1'b1;
                w_ahd_f   = FW'(f);
            end
            if (f > int'(i_cur) && i_dn[f]) begin
                w_rvu_vld = 1'b1;
                w_rvu_f   = FW'(f);
            end
        end
    end

    // Equal distance resolves upward.
    assign o_near_up    = o_any_above && (!o_any_below || ((w_above_f - i_cur) <= (i_cur - w_below_f)));
    assign o_near_floor = o_near_up ? w_above_f : w_below_f;
    assign o_up_vld     = w_ahu_vld | w_rvu_vld;
    assign o_up_floor   = w_ahu_vld ? w_ahu_f : w_rvu_f;
    assign o_dn_vld     = w_ahd_vld | w_rvd_vld;
    assign o_dn_floor   = w_ahd_vld ? w_ahd_f : w_rvd_f;
endmodule

// File: rtl/call_scheduler.sv
// Elevator call latching and SCAN scheduler: latches car/hall calls, clears them on service, picks the next floor.
// Lamps 1 cycle after a press, target/direction 2 cycles after; no backpressure, inputs sampled every cycle.
module call_scheduler
    import call_scheduler_pkg::*;
#(
    parameter int BUTTONS_WIDTH = DEF_FLOORS,
    parameter int FLOOR_W       = $clog2(BUTTONS_WIDTH)
) (
    input  logic                     clock,
    input  logic                     an_reset,
    input  logic                     emrgncy_enable,
    input  logic [BUTTONS_WIDTH-1:0] btn_in,
    input  logic [BUTTONS_WIDTH-2:0] btn_up_out,
    input  logic [BUTTONS_WIDTH-1:1] btn_down_out,
    input  logic [FLOOR_W-1:0]       cur_floor,
    input  logic                     at_floor,
    input  logic                     serviced,
    output logic [FLOOR_W-1:0]       target_floor,
    output logic                     target_valid,
    output logic                     dir_up,
    output logic [BUTTONS_WIDTH-1:0] car_lamp,
    output logic [BUTTONS_WIDTH-2:0] up_lamp,
    output logic [BUTTONS_WIDTH-1:1] down_lamp
);
    localparam int N = BUTTONS_WIDTH;
    localparam logic [FLOOR_W:0] N_L = (FLOOR_W + 1)'(N);

    state_t             r_state;
    logic [N-1:0]       r_car;
    logic [N-2:0]       r_up;
    logic [N-1:1]       r_dn;
    logic [FLOOR_W-1:0] r_tgt;
    logic               r_vld, r_dir;

    logic [N-1:0]       w_up_full, w_dn_full, w_hot;
    logic               w_legal, w_clr_car, w_clr_up, w_clr_dn;
    logic               w_any_above, w_any_below, w_call_here, w_near_up;
    logic               w_up_vld, w_dn_vld;
    logic [FLOOR_W-1:0] w_near_floor, w_up_floor, w_dn_floor;

    assign w_up_full = {1'b0, r_up};
    assign w_dn_full = {r_dn, 1'b0};
    assign w_legal   = {1'b0, cur_floor} < N_L;
    assign w_hot     = {{(N-1){1'b0}}, 1'b1} << cur_floor;

    call_finder #(.N(N), .FW(FLOOR_W)) u_finder (
        .i_car        (r_car),
        .i_up         (w_up_full),
        .i_dn         (w_dn_full),
        .i_cur        (cur_floor),
        .i_at         (at_floor),
        .o_any_above  (w_any_above),
        .o_any_below  (w_any_below),
        .o_call_here  (w_call_here),
        .o_near_up    (w_near_up),
        .o_near_floor (w_near_floor),
        .o_up_vld     (w_up_vld),
        .o_up_floor   (w_up_floor),
        .o_dn_vld     (w_dn_vld),
        .o_dn_floor   (w_dn_floor)
    );

    // Opposite-direction hall call at this floor is only answered when nothing lies ahead.
    always_comb begin
        w_clr_car = serviced && w_legal;
        w_clr_up  = w_clr_car && (r_state == S_IDLE || !r_vld || r_state == S_UP   || !w_any_below);
        w_clr_dn  = w_clr_car && (r_state == S_IDLE || !r_vld || r_state == S_DOWN || !w_any_above);
    end

    always_ff @(posedge clock or negedge an_reset) begin
        if (!an_reset) begin
            r_car <= '0;
            r_up  <= '0;
            r_dn  <= '0;
        end else if (emrgncy_enable) begin
            r_car <= '0;
            r_up  <= '0;
            r_dn  <= '0;
        end else begin
            r_car <= (r_car | btn_in)       & ~(w_clr_car ? w_hot : '0);
            r_up  <= (r_up  | btn_up_out)   & ~(w_clr_up  ? w_hot[N-2:0] : '0);
            r_dn  <= (r_dn  | btn_down_out) & ~(w_clr_dn  ? w_hot[N-1:1] : '0);
        end
    end

    always_ff @(posedge clock or negedge an_reset) begin
        if (!an_reset) begin
            r_state <= S_IDLE;
            r_tgt   <= '0;
            r_vld   <= 1'b0;
            r_dir   <= 1'b1;
        end else if (emrgncy_enable) begin
            r_state <= S_IDLE;
            r_vld   <= 1'b0;
        end else if (w_legal) begin
            case (r_state)
                S_IDLE: begin
                    if (w_call_here) begin
                        r_tgt <= cur_floor;
                        r_vld <= 1'b1;
                    end else if (w_any_above || w_any_below) begin
                        r_tgt   <= w_near_floor;
                        r_vld   <= 1'b1;
                        r_dir   <= w_near_up;
                        r_state <= w_near_up ? S_UP : S_DOWN;
                    end else begin
                        r_vld <= 1'b0;
                    end
                end
                S_UP: begin
                    if (w_up_vld) begin
                        r_tgt <= w_up_floor;
                        r_vld <= 1'b1;
                    end else if (w_any_below) begin
                        r_tgt   <= w_dn_floor;
                        r_vld   <= 1'b1;
                        r_dir   <= 1'b0;
                        r_state <= S_DOWN;
                    end else begin
                        r_vld   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DOWN: begin
                    if (w_dn_vld) begin
                        r_tgt <= w_dn_floor;
                        r_vld <= 1'b1;
                    end else if (w_any_above) begin
                        r_tgt   <= w_up_floor;
                        r_vld   <= 1'b1;
                        r_dir   <= 1'b1;
                        r_state <= S_UP;
                    end else begin
                        r_vld   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_vld   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign target_floor = r_tgt;
    assign target_valid = r_vld;
    assign dir_up       = r_dir;
    assign car_lamp     = r_car;
    assign up_lamp      = r_up;
    assign down_lamp    = r_dn;
endmodule

// File: tb/tb_call_scheduler.sv
// Bench for call_scheduler: directed scenarios plus random traffic against a floor-list reference model.
module tb_call_scheduler;
    localparam int N  = 8;
    localparam int FW = 3;

    logic          clock = 1'b0;
    logic          an_reset = 1'b1;
    logic          emrgncy_enable = 1'b0;
    logic [N-1:0]  btn_in = '0;
    logic [N-2:0]  btn_up_out = '0;
    logic [N-1:1]  btn_down_out = '0;
    logic [FW-1:0] cur_floor = '0;
    logic          at_floor = 1'b1;
    logic          serviced = 1'b0;
    logic [FW-1:0] target_floor;
    logic          target_valid, dir_up;
    logic [N-1:0]  car_lamp;
    logic [N-2:0]  up_lamp;
    logic [N-1:1]  down_lamp;

    always #5 clock = ~clock;

    call_scheduler dut (
        .clock(clock), .an_reset(an_reset), .emrgncy_enable(emrgncy_enable),
        .btn_in(btn_in), .btn_up_out(btn_up_out), .btn_down_out(btn_down_out),
        .cur_floor(cur_floor), .at_floor(at_floor), .serviced(serviced),
        .target_floor(target_floor), .target_valid(target_valid), .dir_up(dir_up),
        .car_lamp(car_lamp), .up_lamp(up_lamp), .down_lamp(down_lamp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one flag per floor per call type; mode 0=idle, 1=going up, 2=going down.
    bit m_car[N];
    bit m_up[N];
    bit m_dn[N];
    int m_mode, m_tgt;
    bit m_vld, m_dir;

    function automatic bit has_call(int f);
        return m_car[f] || m_up[f] || m_dn[f];
    endfunction

    task automatic model_reset();
        for (int f = 0; f < N; f++) begin
            m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0;
        end
        m_mode = 0; m_tgt = 0; m_vld = 0; m_dir = 1;
    endtask

    task automatic model_step();
        int cur, above, below, ah_up, rv_up, ah_dn, rv_dn, up_pick, dn_pick, nmode, ntgt;
        bit nvld, ndir, go_up, cc, cu, cd;
        logic [N-1:0] pu, pd;
        cur = int'(cur_floor);
        if (emrgncy_enable) begin
            for (int f = 0; f < N; f++) begin
                m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0;
            end
            m_mode = 0; m_vld = 0;
            return;
        end
        pu = {1'b0, btn_up_out};
        pd = {btn_down_out, 1'b0};
        above = -1; below = -1; ah_up = -1; rv_up = -1; ah_dn = -1; rv_dn = -1;
        for (int f = 0; f < N; f++) begin
            if (has_call(f) && f > cur && above < 0) above = f;
            if (has_call(f) && f < cur) below = f;
            if ((f > cur || (f == cur && at_floor)) && (m_car[f] || m_up[f]) && ah_up < 0) ah_up = f;
            if (f > cur && m_dn[f]) rv_up = f;
            if ((f < cur || (f == cur && at_floor)) && (m_car[f] || m_dn[f])) ah_dn = f;
            if (f < cur && m_up[f] && rv_dn < 0) rv_dn = f;
        end
        up_pick = (ah_up >= 0) ? ah_up : rv_up;
        dn_pick = (ah_dn >= 0) ? ah_dn : rv_dn;
        nmode = m_mode; ntgt = m_tgt; nvld = m_vld; ndir = m_dir;
        case (m_mode)
            0: if (has_call(cur)) begin
                   ntgt = cur; nvld = 1;
               end else if (above >= 0 || below >= 0) begin
                   go_up = (below < 0) || (above >= 0 && (above - cur) <= (cur - below));
                   nmode = go_up ? 1 : 2; ndir = go_up; ntgt = go_up ? above : below; nvld = 1;
               end else nvld = 0;
            1: if (up_pick >= 0) begin
                   ntgt = up_pick; nvld = 1;
               end else if (below >= 0) begin
                   nmode = 2; ndir = 0; ntgt = dn_pick; nvld = 1;
               end else begin
                   nmode = 0; nvld = 0;
               end
            default: if (dn_pick >= 0) begin
                   ntgt = dn_pick; nvld = 1;
               end else if (above >= 0) begin
                   nmode = 1; ndir = 1; ntgt = up_pick; nvld = 1;
               end else begin
                   nmode = 0; nvld = 0;
               end
        endcase
        cc = 0; cu = 0; cd = 0;
        if (serviced) begin
            if (m_mode == 0 || !m_vld) begin
                cc = 1; cu = 1; cd = 1;
            end else if (m_mode == 1) begin
                cc = 1; cu = 1; cd = (above < 0);
            end else begin
                cc = 1; cd = 1; cu = (below < 0);
            end
        end
        for (int f = 0; f < N; f++) begin
            m_car[f] = (m_car[f] || btn_in[f]) && !(cc && f == cur);
            m_up[f]  = (m_up[f]  || pu[f])     && !(cu && f == cur);
            m_dn[f]  = (m_dn[f]  || pd[f])     && !(cd && f == cur);
        end
        m_mode = nmode; m_tgt = ntgt; m_vld = nvld; m_dir = ndir;
    endtask

    task automatic compare_all();
        logic [N-1:0] ec, eu, ed;
        for (int f = 0; f < N; f++) begin
            ec[f] = m_car[f]; eu[f] = m_up[f]; ed[f] = m_dn[f];
        end
        chk("car_lamp",  32'(car_lamp),     32'(ec));
        chk("up_lamp",   32'(up_lamp),      32'(eu[N-2:0]));
        chk("down_lamp", 32'(down_lamp),    32'(ed[N-1:1]));
        chk("target",    32'(target_floor), 32'(m_tgt));
        chk("valid",     32'(target_valid), 32'(m_vld));
        chk("dir_up",    32'(dir_up),       32'(m_dir));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic clear_btns();
        btn_in = '0; btn_up_out = '0; btn_down_out = '0;
    endtask

    task automatic do_reset();
        an_reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #1;
        an_reset = 1'b1;
    endtask

    initial begin
        do_reset();

        // Calls pending, then asynchronous reset clears everything at once.
        cur_floor = 0; at_floor = 1;
        btn_in = 8'h81; btn_up_out = 7'h04;
        step();
        clear_btns();
        step();
        chk("pend_before_rst", 32'(car_lamp), 32'h81);
        do_reset();
        chk("rst_car", 32'(car_lamp), 0);
        chk("rst_up", 32'(up_lamp), 0);
        chk("rst_valid", 32'(target_valid), 0);
        chk("rst_target", 32'(target_floor), 0);
        chk("rst_dir", 32'(dir_up), 1);

        // Single car call from idle, served.
        btn_in = 8'h40;
        step();
        chk("t2_lamp", 32'(car_lamp[6]), 1);
        chk("t2_valid_early", 32'(target_valid), 0);
        clear_btns();
        step();
        chk("t2_target", 32'(target_floor), 6);
        chk("t2_valid", 32'(target_valid), 1);
        chk("t2_dir", 32'(dir_up), 1);
        cur_floor = 6;
        step();
        serviced = 1;
        step();
        serviced = 0;
        chk("t2_cleared", 32'(car_lamp), 0);
        step();
        chk("t2_idle_valid", 32'(target_valid), 0);

        // Collective up sweep then reversal.
        do_reset();
        cur_floor = 2;
        btn_up_out[3] = 1; btn_in[5] = 1; btn_down_out[4] = 1;
        step();
        clear_btns();
        step();
        chk("t3_first", 32'(target_floor), 3);
        cur_floor = 3;
        step();
        serviced = 1;
        step();
        serviced = 0;
        step();
        chk("t3_second", 32'(target_floor), 5);
        cur_floor = 5;
        step();
        serviced = 1;
        step();
        serviced = 0;
        step();
        chk("t3_rev_dir", 32'(dir_up), 0);
        chk("t3_rev_target", 32'(target_floor), 4);

        // Nearest call from idle, and the tie case.
        do_reset();
        cur_floor = 3;
        btn_in = 8'b0100_0010;
        step();
        clear_btns();
        step();
        chk("t4_near_target", 32'(target_floor), 1);
        chk("t4_near_dir", 32'(dir_up), 0);
        do_reset();
        btn_in = 8'b0010_0010;
        step();
        clear_btns();
        step();
        chk("t4_tie_target", 32'(target_floor), 5);
        chk("t4_tie_dir", 32'(dir_up), 1);

        // Emergency flush with presses ignored.
        do_reset();
        cur_floor = 0;
        btn_in = 8'h30; btn_down_out[7] = 1;
        step();
        clear_btns();
        step();
        emrgncy_enable = 1;
        for (int i = 0; i < 10; i++) begin
            btn_in = 8'($urandom); btn_up_out = 7'($urandom); btn_down_out = 7'($urandom);
            step();
            chk("t5_emg_car", 32'(car_lamp), 0);
            chk("t5_emg_valid", 32'(target_valid), 0);
        end
        emrgncy_enable = 0;
        clear_btns();
        step();
        chk("t5_after_car", 32'(car_lamp), 0);
        chk("t5_after_up", 32'(up_lamp), 0);
        chk("t5_after_down", 32'(down_lamp), 0);

        // Clear beats a held press; re-latch only while still held.
        do_reset();
        cur_floor = 4; at_floor = 1;
        btn_in = 8'h10;
        step();
        step();
        serviced = 1;
        step();
        chk("t6_clear_wins", 32'(car_lamp[4]), 0);
        serviced = 0;
        step();
        chk("t6_relatch", 32'(car_lamp[4]), 1);
        serviced = 1;
        step();
        serviced = 0;
        clear_btns();
        step();
        chk("t6_released", 32'(car_lamp[4]), 0);

        // Random traffic: car mostly drifts toward its target.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [N-1:0] b;
            for (int f = 0; f < N; f++) b[f] = ($urandom_range(0, 19) == 0);
            btn_in = b;
            for (int f = 0; f < N; f++) b[f] = ($urandom_range(0, 24) == 0);
            btn_up_out = b[N-2:0];
            for (int f = 0; f < N; f++) b[f] = ($urandom_range(0, 24) == 0);
            btn_down_out = b[N-1:1];
            if (m_vld && $urandom_range(0, 2) == 0 && int'(cur_floor) != m_tgt)
                cur_floor = (int'(cur_floor) < m_tgt) ? cur_floor + 1 : cur_floor - 1;
            else if ($urandom_range(0, 15) == 0)
                cur_floor = FW'($urandom_range(0, N - 1));
            at_floor = ($urandom_range(0, 9) != 0);
            serviced = (int'(cur_floor) == m_tgt) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            emrgncy_enable = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
